trim_rx: RTL and testbench

- Receive-side deserializer for the bandgap trim link. Sits directly downstream of the trim code generator.
- Runs on the 50 MHz system clock. Oversamples the generator's gated serial clock (ENCLK) and data (DOUT) and rebuilds the 12-bit trim word, LSB first.
- Presents the word as a stable parallel code to the bandgap trim DAC, with a one-cycle valid strobe.
- Frames are delimited by ENCLK idle time; malformed frames are flagged.

---
 rtl/trim_rx_if.sv | 31 +++
 rtl/trim_rx.sv | 168 ++++++++++++++++
 tb/tb_trim_rx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/trim_rx_if.sv
// ============================================================================
// Module      : trim_rx_if
// Description : Serial trim link plus parallel trim-code bundle for trim_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trim_rx_if #(
    parameter int WIDTH = 12
);
    logic             ENCLK;
    logic             DIN;
    logic [WIDTH-1:0] TRIM_OUT;
    logic             TRIM_VALID;
    logic             FRAME_ERR;
    logic             BUSY;

    // Generator / observer side
    modport master (
        output ENCLK, DIN,
        input  TRIM_OUT, TRIM_VALID, FRAME_ERR, BUSY
    );

    // Receiver side
    modport slave (
        input  ENCLK, DIN,
        output TRIM_OUT, TRIM_VALID, FRAME_ERR, BUSY
    );
endinterface

`default_nettype wire

// File: rtl/trim_rx.sv
// ============================================================================
// Module      : trim_rx
// Description : Oversampling deserializer for the bandgap trim link; rebuilds
//               the LSB-first trim word framed by ENCLK idle time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trim_rx #(
    parameter int WIDTH        = 12,
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 60000000,
    parameter int CNT_W        = 26
) (
    input  logic     CLK50,
    input  logic     RST,
    trim_rx_if.slave bus
);

    localparam int               c_bit_w     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_idle_last = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_idle_max  = CNT_W'(IDLE_TIMEOUT);
    localparam logic [c_bit_w-1:0] c_width   = c_bit_w'(WIDTH);
    localparam logic [c_bit_w-1:0] c_one     = c_bit_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_enclk_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_enclk_d;
    logic [WIDTH-1:0]       r_shreg;
    logic [c_bit_w-1:0]     r_bitcnt;
    logic [CNT_W-1:0]       r_idle_cnt;
    logic [WIDTH-1:0]       r_trim;
    logic                   r_valid;
    logic                   r_err;

    logic                   w_event;
    logic                   w_din_s;
    logic                   w_timeout;
    logic                   w_shift;
    logic                   w_load;
    logic                   w_err_set;
    logic                   w_err_clr;
    logic [c_bit_w-1:0]     w_bitcnt_inc;
    logic [c_bit_w-1:0]     w_bitcnt_nxt;

    // Falling edge of the synchronized bit clock is the sample point
    assign w_event      = r_enclk_d & ~r_enclk_sync[SYNC_STAGES-1];
    assign w_din_s      = r_din_sync[SYNC_STAGES-1];
    assign w_timeout    = (r_idle_cnt == c_idle_last) && !w_event;
    assign w_bitcnt_inc = r_bitcnt + c_one;

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift      = 1'b0;
        w_load       = 1'b0;
        w_err_set    = 1'b0;
        w_err_clr    = 1'b0;
        w_bitcnt_nxt = r_bitcnt;
        case (r_state)
            ST_IDLE: begin
                if (w_event) begin
                    w_shift      = 1'b1;
                    w_bitcnt_nxt = c_one;
                    w_state_nxt  = ST_RECV;
                end
            end
            ST_RECV: begin
                if (w_event) begin
                    w_shift      = 1'b1;
                    w_bitcnt_nxt = w_bitcnt_inc;
                    if (w_bitcnt_inc == c_width) begin
                        w_state_nxt = ST_FULL;
                    end
                end else if (w_timeout) begin
                    w_err_set    = 1'b1;
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (w_event) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end else if (w_timeout) begin
                    w_load       = 1'b1;
                    w_err_clr    = 1'b1;
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_timeout) begin
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            r_enclk_sync <= '0;
            r_din_sync   <= '0;
            r_enclk_d    <= 1'b0;
            r_shreg      <= '0;
            r_bitcnt     <= '0;
            r_idle_cnt   <= '0;
            r_trim       <= '0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_enclk_sync <= {r_enclk_sync[SYNC_STAGES-2:0], bus.ENCLK};
            r_din_sync   <= {r_din_sync[SYNC_STAGES-2:0], bus.DIN};
            r_enclk_d    <= r_enclk_sync[SYNC_STAGES-1];
            r_bitcnt     <= w_bitcnt_nxt;
            r_valid      <= w_load;

            if (w_shift) begin
                r_shreg <= {w_din_s, r_shreg[WIDTH-1:1]};
            end

            if (w_event) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != c_idle_max) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end

            // Word is committed whole, only once the frame has gone idle
            if (w_load) begin
                r_trim <= r_shreg;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.TRIM_OUT   = r_trim;
    assign bus.TRIM_VALID = r_valid;
    assign bus.FRAME_ERR  = r_err;
    assign bus.BUSY       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_trim_rx.sv
// ============================================================================
// Module      : tb_trim_rx
// Description : Scoreboard bench for trim_rx with directed and random frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trim_rx;

    localparam int c_width = 12;
    localparam int c_sync  = 2;
    localparam int c_to    = 32;
    localparam int c_lat   = c_sync + 1 + c_to;

    typedef struct {
        logic [c_width-1:0] word;
        int                 cyc;
    } exp_t;

    logic clk50;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   last_fall;

    exp_t               q[$];
    logic [c_width-1:0] exp_trim;
    logic               exp_err;
    logic [c_width-1:0] prev_trim;
    logic               prev_valid;

    trim_rx_if #(.WIDTH(c_width)) bus ();

    trim_rx #(
        .WIDTH       (c_width),
        .SYNC_STAGES (c_sync),
        .IDLE_TIMEOUT(c_to),
        .CNT_W       (26)
    ) dut (
        .CLK50(clk50),
        .RST  (rst),
        .bus  (bus)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    initial cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk50);
            #1;
        end
    endtask

    // Drive nbits ENCLK periods; DIN changes with the rising edge
    task automatic send_frame(input logic [c_width-1:0] word, input int nbits,
                              input int hi, input int lo, input bit good);
        for (int i = 0; i < nbits; i++) begin
            bus.ENCLK = 1'b1;
            bus.DIN   = (i < c_width) ? word[i] : 1'b1;
            wait_cyc(hi);
            bus.ENCLK = 1'b0;
            last_fall = cyc;
            if (good && i == nbits - 1) begin
                q.push_back('{word: word, cyc: last_fall + c_lat});
            end
            wait_cyc(lo);
        end
    endtask

    // Reference model: a frame is good only with exactly WIDTH bits
    task automatic run_frame(input string name, input logic [c_width-1:0] word,
                             input int nbits, input int hi, input int lo);
        bit good;
        good = (nbits == c_width);
        send_frame(word, nbits, hi, lo, good);
        check({name, "_busy_mid"}, bus.BUSY, 1);
        if (good) begin
            exp_trim = word;
            exp_err  = 1'b0;
        end else begin
            exp_err  = 1'b1;
        end
        wait_cyc(c_to + 12);
        check({name, "_busy_end"}, bus.BUSY, 0);
        check({name, "_err"}, bus.FRAME_ERR, exp_err);
        check({name, "_trim"}, bus.TRIM_OUT, exp_trim);
        check({name, "_pending_valid"}, q.size(), 0);
        q.delete();
    endtask

    always @(negedge clk50) begin
        if (rst) begin
            prev_trim  = bus.TRIM_OUT;
            prev_valid = 1'b0;
        end else begin
            if (bus.TRIM_VALID) begin
                check("valid_one_cycle", prev_valid, 0);
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL valid_unexpected: TRIM_VALID with no good frame pending, TRIM_OUT=%0h", bus.TRIM_OUT);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("valid_word", bus.TRIM_OUT, e.word);
                    check("valid_cycle", cyc, e.cyc);
                    check("valid_err", bus.FRAME_ERR, 0);
                    check("valid_busy", bus.BUSY, 0);
                end
            end else begin
                check("trim_hold", bus.TRIM_OUT, prev_trim);
            end
            prev_trim  = bus.TRIM_OUT;
            prev_valid = bus.TRIM_VALID;
        end
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        last_fall = 0;
        exp_trim  = '0;
        exp_err   = 1'b0;
        rst       = 1'b1;
        bus.ENCLK = 1'b0;
        bus.DIN   = 1'b0;
        wait_cyc(3);
        check("rst_trim", bus.TRIM_OUT, 0);
        check("rst_valid", bus.TRIM_VALID, 0);
        check("rst_err", bus.FRAME_ERR, 0);
        check("rst_busy", bus.BUSY, 0);
        rst = 1'b0;
        wait_cyc(3);

        run_frame("good_a5c", 12'hA5C, 12, 10, 10);
        run_frame("b2b_001", 12'h001, 12, 10, 10);
        run_frame("b2b_fff", 12'hFFF, 12, 10, 10);
        run_frame("short7", 12'h3FF, 7, 10, 10);
        run_frame("good_123", 12'h123, 12, 10, 10);
        run_frame("overrun14", 12'hABC, 14, 10, 10);

        // Abort mid-frame: outputs must clear without waiting for a clock
        send_frame(12'h800, 5, 10, 10, 1'b0);
        @(posedge clk50);
        #3;
        rst = 1'b1;
        #1;
        check("arst_trim", bus.TRIM_OUT, 0);
        check("arst_valid", bus.TRIM_VALID, 0);
        check("arst_err", bus.FRAME_ERR, 0);
        check("arst_busy", bus.BUSY, 0);
        exp_trim = '0;
        exp_err  = 1'b0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(3);
        run_frame("after_rst_0f0", 12'h0F0, 12, 10, 10);

        // Falls spaced exactly IDLE_TIMEOUT cycles apart land on the last count
        run_frame("boundary", 12'h5A3, 12, 16, 16);

        for (int k = 0; k < 20; k++) begin
            int sel;
            int nb;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      nb = c_width;
            else if (sel < 8) nb = int'($urandom_range(1, c_width - 1));
            else              nb = int'($urandom_range(c_width + 1, c_width + 3));
            run_frame("random", 12'($urandom), nb,
                      int'($urandom_range(3, 14)), int'($urandom_range(3, 14)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
